// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_pkg
// Purpose  : State encoding, seven-segment table and width helper for the timer
// Revision : 1.0
// ============================================================================
package countdown_timer_pkg;

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_run   = 2'd1;
   localparam logic [1:0] c_pause = 2'd2;
   localparam logic [1:0] c_done  = 2'd3;

   localparam logic [0:6] c_blank = 7'b1111111;

   // Segments a..g, active low; entry 0 is the first row listed.
   localparam logic [0:15][0:6] c_seg_table = {
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   function automatic int unsigned ceil_log2(input int unsigned value);
      int unsigned w;
      w = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Purpose  : Combinational 4-bit to active-low seven-segment decode
// Revision : 1.0
// ============================================================================
module hex7seg
   import countdown_timer_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [0:6] o_seg
);

   assign o_seg = c_seg_table[i_digit];

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Purpose  : Prescaled 4-bit countdown with pause, done pulse and blinking hex
// Revision : 1.0
// ============================================================================
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000000
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       run,
   output logic [3:0] count,
   output logic       done,
   output logic       expired,
   output logic [0:6] hex
);

   localparam int unsigned      c_pw        = ceil_log2(TICK_DIV);
   localparam logic [c_pw-1:0]  c_presc_max = c_pw'(TICK_DIV - 1);

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [c_pw-1:0] r_presc;
   logic [3:0]      r_count;
   logic            r_blink;
   logic            r_done;
   logic [0:6]      r_hex;
   logic [0:6]      w_seg;
   logic            w_counting;
   logic            w_tick;
   logic            w_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (load) begin
         w_state_nxt = c_idle;
      end else begin
         case (r_state)
            c_idle:  if (run && (r_count != 4'd0)) w_state_nxt = c_run;
            c_run: begin
               if (w_tick && (r_count == 4'd1)) w_state_nxt = c_done;
               else if (!run)                   w_state_nxt = c_pause;
            end
            c_pause: if (run) w_state_nxt = c_run;
            c_done:  w_state_nxt = c_done;
            default: w_state_nxt = c_idle;
         endcase
      end
   end

   always_comb begin
      w_counting = (r_state == c_run) || (r_state == c_done);
      w_tick     = w_counting && (r_presc == c_presc_max);
      w_last     = (r_state == c_run) && w_tick && (r_count == 4'd1);
      expired    = (r_state == c_done);
   end

   // Load wins over ticking; the prescaler freezes outside RUN/DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
         r_count <= 4'd0;
         r_blink <= 1'b0;
         r_done  <= 1'b0;
      end else if (load) begin
         r_presc <= '0;
         r_count <= load_val;
         r_blink <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_counting) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
         end
         if ((r_state == c_run) && w_tick && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
         end
         if ((r_state == c_done) && w_tick) begin
            r_blink <= ~r_blink;
         end
      end
   end

   hex7seg u_hex7seg (
      .i_digit (r_count),
      .o_seg   (w_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hex <= c_seg_table[0];
      end else begin
         r_hex <= ((r_state == c_done) && r_blink) ? c_blank : w_seg;
      end
   end

   assign count = r_count;
   assign done  = r_done;
   assign hex   = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Purpose  : Directed vector bench for countdown_timer with TICK_DIV=4
// Revision : 1.0
// ============================================================================
module tb_countdown_timer;

   logic       clk;
   logic       rst;
   logic       load;
   logic [3:0] load_val;
   logic       run;
   logic [3:0] count;
   logic       done;
   logic       expired;
   logic [0:6] hex;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       rst;
      logic       load;
      logic [3:0] lv;
      logic       run;
      logic [3:0] e_count;
      logic       e_done;
      logic       e_exp;
      logic [6:0] e_hex;
   } vec_t;

   vec_t vecs[26];
   logic [6:0] seg_exp[16];

   countdown_timer #(.TICK_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .run      (run),
      .count    (count),
      .done     (done),
      .expired  (expired),
      .hex      (hex)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic r, input logic l, input logic [3:0] v,
                               input logic rn, input logic [3:0] c, input logic d,
                               input logic e, input logic [6:0] h);
      vec_t t;
      t.rst = r; t.load = l; t.lv = v; t.run = rn;
      t.e_count = c; t.e_done = d; t.e_exp = e; t.e_hex = h;
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic l, input logic [3:0] v, input logic rn);
      rst = r; load = l; load_val = v; run = rn;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] c, input logic d,
                          input logic e, input logic [6:0] h);
      chk({tag, ".count"},   32'(count),   32'(c));
      chk({tag, ".done"},    32'(done),    32'(d));
      chk({tag, ".expired"}, 32'(expired), 32'(e));
      chk({tag, ".hex"},     32'(hex),     32'(h));
   endtask

   initial begin
      seg_exp = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

      // Countdown from 3 into DONE, blink, then reload 9 out of DONE.
      vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 7'b0000001);
      vecs[1]  = mk(0, 1, 3, 0, 3, 0, 0, 7'b0000001);
      vecs[2]  = mk(0, 0, 0, 1, 3, 0, 0, 7'b0000110);
      vecs[3]  = mk(0, 0, 0, 1, 3, 0, 0, 7'b0000110);
      vecs[4]  = mk(0, 0, 0, 1, 3, 0, 0, 7'b0000110);
      vecs[5]  = mk(0, 0, 0, 1, 3, 0, 0, 7'b0000110);
      vecs[6]  = mk(0, 0, 0, 1, 2, 0, 0, 7'b0000110);
      vecs[7]  = mk(0, 0, 0, 1, 2, 0, 0, 7'b0010010);
      vecs[8]  = mk(0, 0, 0, 1, 2, 0, 0, 7'b0010010);
      vecs[9]  = mk(0, 0, 0, 1, 2, 0, 0, 7'b0010010);
      vecs[10] = mk(0, 0, 0, 1, 1, 0, 0, 7'b0010010);
      vecs[11] = mk(0, 0, 0, 1, 1, 0, 0, 7'b1001111);
      vecs[12] = mk(0, 0, 0, 1, 1, 0, 0, 7'b1001111);
      vecs[13] = mk(0, 0, 0, 1, 1, 0, 0, 7'b1001111);
      vecs[14] = mk(0, 0, 0, 1, 0, 1, 1, 7'b1001111);
      vecs[15] = mk(0, 0, 0, 1, 0, 0, 1, 7'b0000001);
      vecs[16] = mk(0, 0, 0, 1, 0, 0, 1, 7'b0000001);
      vecs[17] = mk(0, 0, 0, 1, 0, 0, 1, 7'b0000001);
      vecs[18] = mk(0, 0, 0, 1, 0, 0, 1, 7'b0000001);
      vecs[19] = mk(0, 0, 0, 0, 0, 0, 1, 7'b1111111);
      vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 7'b1111111);
      vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 7'b1111111);
      vecs[22] = mk(0, 0, 0, 0, 0, 0, 1, 7'b1111111);
      vecs[23] = mk(0, 0, 0, 0, 0, 0, 1, 7'b0000001);
      vecs[24] = mk(0, 1, 9, 0, 9, 0, 0, 7'b0000001);
      vecs[25] = mk(0, 0, 0, 0, 9, 0, 0, 7'b0000100);

      drive(1, 0, 0, 0);
      for (int i = 0; i < 26; i++) begin
         drive(vecs[i].rst, vecs[i].load, vecs[i].lv, vecs[i].run);
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_done,
                 vecs[i].e_exp, vecs[i].e_hex);
      end

      // Load 0 then run: must stay idle with no done pulse.
      drive(0, 1, 0, 0);
      step();
      chk_all("zero_load", 0, 0, 0, 7'b0000100);
      drive(0, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         step();
         chk_all($sformatf("zero_run%0d", i), 0, 0, 0, 7'b0000001);
      end

      // Pause after two RUN cycles, hold ten, resume from frozen prescaler.
      drive(0, 1, 5, 0); step();
      drive(0, 0, 0, 1); step(); step();
      drive(0, 0, 0, 0); step();
      for (int i = 0; i < 10; i++) begin
         step();
         chk_all($sformatf("pause%0d", i), 5, 0, 0, 7'b0100100);
      end
      drive(0, 0, 0, 1); step();
      chk("resume.edge0", 32'(count), 32'd5);
      step();
      chk("resume.edge1", 32'(count), 32'd5);
      step();
      chk("resume.edge2", 32'(count), 32'd4);

      // Run drops on the tick cycle: decrement still happens, then pause.
      step(); step(); step();
      chk("pretick", 32'(count), 32'd4);
      drive(0, 0, 0, 0); step();
      chk("droptick", 32'(count), 32'd3);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_all($sformatf("drophold%0d", i), 3, 0, 0, 7'b0000110);
      end

      // Reset beats load mid-run.
      drive(0, 1, 7, 0); step();
      drive(0, 0, 0, 1); step(); step();
      chk("run7", 32'(count), 32'd7);
      drive(1, 1, 9, 1); step();
      chk_all("rst_over_load", 0, 0, 0, 7'b0000001);
      drive(0, 0, 0, 1);
      for (int i = 0; i < 6; i++) begin
         step();
         chk_all($sformatf("post_rst%0d", i), 0, 0, 0, 7'b0000001);
      end

      // Decode table through the load path, F included.
      for (int v = 0; v < 16; v++) begin
         drive(0, 1, 4'(v), 0); step();
         drive(0, 0, 0, 0); step();
         chk($sformatf("dec%0d.count", v), 32'(count), 32'(v));
         chk($sformatf("dec%0d.hex", v), 32'(hex), 32'(seg_exp[v]));
      end

      // Reset out of DONE.
      drive(0, 1, 1, 0); step();
      drive(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step();
      chk("reach_done", 32'(expired), 32'd1);
      drive(1, 0, 0, 0); step();
      chk_all("rst_in_done", 0, 0, 0, 7'b0000001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
